// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one synchronous 16-bit RAM between requester A (CPU data)
// and requester B (loader/DMA). Each access runs IDLE -> ISSUE -> DONE; under
// contention ownership alternates because DONE re-arbitrates straight to the
// other requester.
// Optional macro RAM_ARB_STATS_EN adds per-port saturating ack counters with a
// synchronous clear (i_cnt_clr, o_cnt_a, o_cnt_b).
module ram_arbiter #(
    parameter int BASE_ADDR  = 0,
    parameter int MEM_SIZE   = 1024,
    parameter int PRIORITY_A = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_a,
    input  logic        i_we_a,
    input  logic [15:0] i_addr_a,
    input  logic [15:0] i_wdata_a,
    output logic        o_ack_a,
    output logic [15:0] o_rdata_a,
    input  logic        i_req_b,
    input  logic        i_we_b,
    input  logic [15:0] i_addr_b,
    input  logic [15:0] i_wdata_b,
    output logic        o_ack_b,
    output logic [15:0] o_rdata_b,
    output logic        o_ram_ce,
    output logic        o_ram_we,
    output logic [15:0] o_ram_addr,
    output logic [15:0] o_ram_wdata,
    input  logic [15:0] i_ram_rdata,
`ifdef RAM_ARB_STATS_EN
    input  logic        i_cnt_clr,
    output logic [15:0] o_cnt_a,
    output logic [15:0] o_cnt_b,
`endif
    output logic        o_busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    // 17-bit window so BASE_ADDR+MEM_SIZE = 65536 does not wrap.
    localparam logic [16:0] LO_ADDR = 17'(BASE_ADDR);
    localparam logic [16:0] SPAN    = 17'(MEM_SIZE);

    // Offset from base wraps to >= 65537 when addr < base, so one compare covers both bounds.
    function automatic logic in_range(input logic [15:0] addr);
        logic [16:0] off;
        off = {1'b0, addr} - LO_ADDR;
        return off < SPAN;
    endfunction

    state_t      state_q, state_d;
    logic        owner_q, owner_d;          // 0 = A, 1 = B
    logic        ram_ce_q, ram_ce_d;
    logic        ram_we_q, ram_we_d;
    logic [15:0] ram_addr_q, ram_addr_d;
    logic [15:0] ram_wdata_q, ram_wdata_d;
    logic        ack_a_q, ack_a_d;
    logic        ack_b_q, ack_b_d;
    logic        rd_ok_q, rd_ok_d;          // DONE cycle carries in-range read data

    logic        grant;
    logic        grant_b;
    logic        sel_we;
    logic [15:0] sel_addr;
    logic [15:0] sel_wdata;

    // Winner selection: ties in IDLE go by PRIORITY_A, DONE hands over to the non-owner only.
    always_comb begin
        grant   = 1'b0;
        grant_b = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_req_a || i_req_b) begin
                    grant   = 1'b1;
                    grant_b = i_req_b && (!i_req_a || (PRIORITY_A == 0));
                end
            end
            DONE: begin
                if (!owner_q && i_req_b) begin
                    grant   = 1'b1;
                    grant_b = 1'b1;
                end else if (owner_q && i_req_a) begin
                    grant   = 1'b1;
                    grant_b = 1'b0;
                end
            end
            default: ;
        endcase
        sel_we    = grant_b ? i_we_b    : i_we_a;
        sel_addr  = grant_b ? i_addr_b  : i_addr_a;
        sel_wdata = grant_b ? i_wdata_b : i_wdata_a;
    end

    // Next-state and next-output computation for the access sequencer.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ram_ce_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ack_a_d     = 1'b0;
        ack_b_d     = 1'b0;
        rd_ok_d     = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (grant) begin
                    state_d     = ISSUE;
                    owner_d     = grant_b;
                    ram_addr_d  = sel_addr;
                    ram_wdata_d = sel_wdata;
                    ram_ce_d    = in_range(sel_addr);
                    ram_we_d    = sel_we && in_range(sel_addr);
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                state_d = DONE;
                ack_a_d = !owner_q;
                ack_b_d = owner_q;
                rd_ok_d = ram_ce_q && !ram_we_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer state and registered RAM/ack outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            ram_ce_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ack_a_q     <= 1'b0;
            ack_b_q     <= 1'b0;
            rd_ok_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ram_ce_q    <= ram_ce_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ack_a_q     <= ack_a_d;
            ack_b_q     <= ack_b_d;
            rd_ok_q     <= rd_ok_d;
        end
    end

    // RAM read data arrives one cycle after ISSUE, i.e. during DONE, so it is steered, not registered.
    assign o_ack_a     = ack_a_q;
    assign o_ack_b     = ack_b_q;
    assign o_rdata_a   = (ack_a_q && rd_ok_q) ? i_ram_rdata : 16'h0000;
    assign o_rdata_b   = (ack_b_q && rd_ok_q) ? i_ram_rdata : 16'h0000;
    assign o_ram_ce    = ram_ce_q;
    assign o_ram_we    = ram_we_q;
    assign o_ram_addr  = ram_addr_q;
    assign o_ram_wdata = ram_wdata_q;
    assign o_busy      = (state_q != IDLE);

`ifdef RAM_ARB_STATS_EN
    logic [15:0] cnt_a_q, cnt_a_d;
    logic [15:0] cnt_b_q, cnt_b_d;

    // Saturating ack counters; clear overrides a same-cycle increment.
    always_comb begin
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        if (i_cnt_clr) begin
            cnt_a_d = '0;
            cnt_b_d = '0;
        end else begin
            if (ack_a_q && (cnt_a_q != 16'hFFFF)) cnt_a_d = cnt_a_q + 16'd1;
            if (ack_b_q && (cnt_b_q != 16'hFFFF)) cnt_b_d = cnt_b_q + 16'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end

    assign o_cnt_a = cnt_a_q;
    assign o_cnt_b = cnt_b_q;
`endif

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-port arbiter sharing one synchronous-read, synchronous-write 16-bit RAM between requester A (CPU data side) and requester B (program loader / DMA).
- Sits between the requesters and the RAM's clock/ce/we/addr/wdata/rdata port.
- Sequences every access through a 3-state FSM, latches the winner's command, returns read data with a one-cycle ack, and alternates ownership under contention.

Parameters:
- BASE_ADDR, 0, first valid RAM word address.
- MEM_SIZE, 1024, number of valid words; valid range is BASE_ADDR to BASE_ADDR+MEM_SIZE-1.
- PRIORITY_A, 1, when both requesters request from IDLE: 1 = A wins, 0 = B wins.

Ports:
- i_clk  in  1  clock; all flops on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_req_a  in  1  A requests an access; held high until o_ack_a.
- i_we_a  in  1  A write (1) or read (0).
- i_addr_a  in  16  A word address.
- i_wdata_a  in  16  A write data.
- o_ack_a  out  1  one-cycle access-complete pulse to A.
- o_rdata_a  out  16  A read data, valid while o_ack_a=1.
- i_req_b, i_we_b, i_addr_b, i_wdata_b, o_ack_b, o_rdata_b: same as the A ports, for B.
- o_ram_ce  out  1  RAM chip enable.
- o_ram_we  out  1  RAM write enable.
- o_ram_addr  out  16  RAM address.
- o_ram_wdata  out  16  RAM write data.
- i_ram_rdata  in  16  RAM registered read data; 1-cycle latency.
- o_busy  out  1  high when the FSM is not in IDLE.

Behaviour:
- Reset, asynchronous, active-low:
  - state=IDLE, owner=A, last_served=B.
  - o_ram_ce=0, o_ram_we=0, o_ram_addr=0, o_ram_wdata=0.
  - o_ack_a=0, o_ack_b=0, o_rdata_a=0, o_rdata_b=0, o_busy=0.
- FSM states: IDLE, ISSUE, DONE.
- IDLE:
  - At a rising edge with any request high, pick the winner:
    - Only one requester high: that requester wins.
    - Both high: PRIORITY_A decides.
  - Latch owner, we, addr and wdata from the winner into the o_ram_* registers, then go to ISSUE.
  - No request: stay in IDLE.
- ISSUE, exactly 1 cycle:
  - o_ram_ce=1 if the latched address is in range, else 0.
  - o_ram_we = latched we AND in-range.
  - The RAM captures the access at the edge ending ISSUE. Go to DONE.
- DONE, exactly 1 cycle:
  - o_ack_<owner>=1.
  - o_rdata_<owner> = i_ram_rdata for an in-range read; 16'h0000 for an out-of-range read or for any write.
  - o_ram_ce=0 and o_ram_we=0.
  - The other port's ack and rdata are 0.
- Leaving DONE (re-arbitration): the owner's request is ignored at this edge.
  - The requester drops or keeps req after seeing ack; its next request is sampled one cycle later at the earliest.
  - If the non-owner requests, it is granted and latched: go directly to ISSUE.
  - Otherwise go to IDLE.
  - Result under contention: strict alternation A,B,A,B.
  - Peak throughput: one access per 2 cycles while alternating; one per 3 cycles for a single requester.
- Latency: request sampled at edge N gives ack high during cycle N+2 (from IDLE).
- Requester command inputs are sampled only at the grant edge; changes afterwards do not affect the in-flight access.
- Out-of-range address (addr < BASE_ADDR or addr >= BASE_ADDR+MEM_SIZE):
  - No RAM enable.
  - Still acked in the normal 2 cycles, with rdata 0.
  - Writes are dropped.
- Address compare uses 17-bit arithmetic, so BASE_ADDR+MEM_SIZE=65536 does not wrap.
- Reset asserted mid-access:
  - All outputs return immediately to their reset values; no ack is issued.
  - A write in ISSUE may or may not reach the RAM; requesters must reissue it.
- Simultaneous events:
  - A new request arriving during ISSUE or DONE is held by the requester and served by the DONE→ISSUE or IDLE path.
  - Requests are never lost while req stays high.

Optional Feature:
- Macro RAM_ARB_STATS_EN.
- Defined:
  - Adds outputs o_cnt_a[15:0] and o_cnt_b[15:0], reset to 0.
  - Each counter increments by 1 on every ack of its port, in-range or not, and saturates at 16'hFFFF.
  - Adds input i_cnt_clr, a synchronous clear; if clear and increment occur in the same cycle, clear wins.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single read:
  - Stimulus: preload mem[0x010]=16'hBEEF; A reads 0x010.
  - Response: o_ram_ce=1 for one cycle with o_ram_addr=0x010; o_ack_a pulses 2 cycles after the request edge with o_rdata_a=16'hBEEF; o_ack_b stays 0.
- Write then read:
  - Stimulus: B writes 16'h1234 to 0x3FF; B then reads 0x3FF.
  - Response: o_ram_we=1 during ISSUE; the write ack carries rdata=0; the read returns 16'h1234.
- Contention:
  - Stimulus: A and B both hold req for 4 accesses each, PRIORITY_A=1.
  - Response: grant order A,B,A,B,A,B,A,B; acks exactly 2 cycles apart; no cycle with both acks high.
- Out of range:
  - Stimulus: A writes 16'hFFFF to 0x0400, then A reads 0x0400, with MEM_SIZE=1024.
  - Response: o_ram_ce stays 0; both accesses are acked with rdata 0; mem[0x000] is unchanged.
- Reset mid-op:
  - Stimulus: assert i_rst_n=0 during ISSUE of an A read; release; A re-requests.
  - Response: o_busy=0 and all outputs 0 immediately; no stale ack; the re-request completes normally.
- Stats (RAM_ARB_STATS_EN):
  - Stimulus: 3 A accesses and 5 B accesses; then pulse i_cnt_clr.
  - Response: o_cnt_a=3 and o_cnt_b=5; both read 0 after the clear.
